// File: rtl/uart_fifo_link.sv
// uart_fifo_link: buffered UART transceiver with TX/RX FIFOs, parity, stop bits and oversampled receive
module uart_fifo_link #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ena,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_signal,
  output logic                          tx_busy,
  input  logic                          rx_signal,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          err_clear,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int DIVR = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV  = DIVR < 1 ? 1 : DIVR;
  localparam int DCW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_t;
  logic [DCW-1:0] div_cnt;
  logic tick;
  assign tick = ena && div_cnt == DCW'(DIV - 1);
  always_ff @(posedge clk)
    if (reset) div_cnt <= '0;
    else div_cnt <= tick ? '0 : div_cnt + DCW'(ena);
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;
  assign tx_ready = tx_count != CW'(FIFO_DEPTH);
  assign tx_push = tx_valid && tx_ready;
  assign tx_head = tx_mem[tx_rp];
  always_ff @(posedge clk)
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= tx_data;
        tx_wp <= tx_wp + 1'b1;
      end
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  st_t tx_st, tx_nxt;
  logic [TW-1:0] tx_tc;
  logic [3:0] tx_bit;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic tx_par, tx_end;
  assign tx_end = tick && tx_tc == TW'(OVERSAMPLE - 1);
  always_comb begin
    tx_nxt = tx_st;
    tx_pop = 1'b0;
    case (tx_st)
      IDLE: if (ena && tx_count != '0) begin
        tx_pop = 1'b1;
        tx_nxt = START;
      end
      START: if (tx_end) tx_nxt = DATA;
      DATA: if (tx_end && tx_bit == 4'(DATA_WIDTH - 1)) tx_nxt = PARITY != 0 ? PAR : STOP;
      PAR: if (tx_end) tx_nxt = STOP;
      default: if (tx_end && tx_bit == 4'(STOP_BITS - 1)) begin
        tx_pop = tx_count != '0;
        tx_nxt = tx_pop ? START : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      tx_st <= IDLE;
      tx_tc <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_nxt;
      tx_tc <= (tx_nxt != tx_st || tx_end) ? '0 : tx_tc + TW'(tick);
      tx_bit <= tx_nxt != tx_st ? '0 : tx_bit + 4'(tx_end);
      if (tx_pop) begin
        tx_sh <= tx_head;
        tx_par <= ^tx_head ^ (PARITY == 1);
      end else if (tx_end && tx_st == DATA) tx_sh <= tx_sh >> 1;
    end
  assign tx_signal = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PAR ? tx_par : 1'b1;
  assign tx_busy = tx_st != IDLE || tx_count != '0;
  logic rx_s1, rx_s2, rx_prev;
  always_ff @(posedge clk)
    if (reset) {rx_prev, rx_s2, rx_s1} <= 3'b111;
    else {rx_prev, rx_s2, rx_s1} <= {ena ? rx_s2 : rx_prev, rx_s1, rx_signal};
  st_t rx_st, rx_nxt;
  logic [TW-1:0] rx_tc;
  logic [3:0] rx_bit;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic rx_pbit, rx_end, rx_mid, rx_wr, rx_perr, rx_push, rx_pop;
  assign rx_end = tick && rx_tc == TW'(OVERSAMPLE - 1);
  assign rx_mid = tick && rx_tc == TW'(OVERSAMPLE / 2 - 1);
  always_comb begin
    rx_nxt = rx_st;
    rx_wr = 1'b0;
    case (rx_st)
      IDLE: if (ena && rx_prev && !rx_s2) rx_nxt = START;
      START: if (rx_mid) rx_nxt = rx_s2 ? IDLE : DATA;
      DATA: if (rx_end && rx_bit == 4'(DATA_WIDTH - 1)) rx_nxt = PARITY != 0 ? PAR : STOP;
      PAR: if (rx_end) rx_nxt = STOP;
      default: if (rx_end) begin
        rx_wr = 1'b1;
        rx_nxt = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      rx_st <= IDLE;
      rx_tc <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_pbit <= 1'b0;
    end else begin
      rx_st <= rx_nxt;
      rx_tc <= (rx_nxt != rx_st || rx_end) ? '0 : rx_tc + TW'(tick);
      rx_bit <= rx_nxt != rx_st ? '0 : rx_bit + 4'(rx_end);
      if (rx_end && rx_st == DATA) rx_sh <= {rx_s2, rx_sh[DATA_WIDTH-1:1]};
      if (rx_end && rx_st == PAR) rx_pbit <= rx_s2;
    end
  assign rx_perr = PARITY != 0 && (^rx_sh ^ rx_pbit ^ (PARITY == 1));
  logic [DATA_WIDTH+1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  assign rx_valid = rx_count != '0;
  assign rx_push = rx_wr && rx_count != CW'(FIFO_DEPTH);
  assign rx_pop = rx_valid && rx_ready;
  assign {rx_data, rx_parity_err, rx_frame_err} = rx_valid ? rx_mem[rx_rp] : '0;
  always_ff @(posedge clk)
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_count <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= {rx_sh, rx_perr, !rx_s2};
        rx_wp <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      rx_overrun <= (rx_wr && !rx_push) ? 1'b1 : err_clear ? 1'b0 : rx_overrun;
    end
endmodule

// File: tb/tb_uart_fifo_link.sv
// tb_uart_fifo_link: self-checking bench for uart_fifo_link (8N1 loopback instance and 8E2 instance)
module tb_uart_fifo_link;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic ena [2], txv [2], txr [2], txs [2], txb [2], drv [2], loop [2];
  logic rxpe [2], rxfe [2], rxv [2], rxr [2], rxo [2], ec [2];
  logic [7:0] txd [2], rxd [2];
  logic [4:0] txc [2], rxc [2];
  logic [7:0] vals [256];
  int total = 0, bad = 0;
  uart_fifo_link #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) u0 (
    .clk(clk), .reset(reset), .ena(ena[0]), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
    .tx_signal(txs[0]), .tx_busy(txb[0]), .rx_signal(loop[0] ? txs[0] : drv[0]), .rx_data(rxd[0]),
    .rx_parity_err(rxpe[0]), .rx_frame_err(rxfe[0]), .rx_valid(rxv[0]), .rx_ready(rxr[0]),
    .rx_overrun(rxo[0]), .err_clear(ec[0]), .tx_count(txc[0]), .rx_count(rxc[0]));
  uart_fifo_link #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .ena(ena[1]), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(txr[1]),
    .tx_signal(txs[1]), .tx_busy(txb[1]), .rx_signal(loop[1] ? txs[1] : drv[1]), .rx_data(rxd[1]),
    .rx_parity_err(rxpe[1]), .rx_frame_err(rxfe[1]), .rx_valid(rxv[1]), .rx_ready(rxr[1]),
    .rx_overrun(rxo[1]), .err_clear(ec[1]), .tx_count(txc[1]), .rx_count(rxc[1]));
  typedef struct {
    logic [7:0] d;
    bit badp;
    bit stoplow;
    logic pe;
    logic fe;
  } vec_t;
  vec_t tbl [6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic put(input int k, input logic b);
    drv[k] = b;
    repeat (16) @(negedge clk);
  endtask
  task automatic drive_frame(input int k, input logic [7:0] d, input bit badp, input bit stoplow);
    put(k, 1'b0);
    for (int i = 0; i < 8; i++) put(k, d[i]);
    if (k == 1) put(k, ^d ^ badp);
    put(k, !stoplow);
    if (k == 1) put(k, 1'b1);
    drv[k] = 1'b1;
  endtask
  task automatic pop(input int k);
    @(negedge clk) rxr[k] = 1'b1;
    @(negedge clk) rxr[k] = 1'b0;
  endtask
  task automatic wait_rx(input int k, input int budget);
    int c = 0;
    while (!rxv[k] && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("rx_valid_wait", rxv[k], 1);
  endtask
  task automatic stream(input int k, input int n, input bit rnd);
    logic [7:0] q [$];
    logic [7:0] e;
    int i = 0, got = 0, lim;
    lim = n * (k == 1 ? 192 : 160) * 3 + 1000;
    for (int c = 0; c < lim && got < n; c++) begin
      @(negedge clk);
      if (rnd) begin
        ena[k] = $urandom_range(0, 7) != 0;
        rxr[k] = 1'($urandom_range(0, 1));
      end else rxr[k] = 1'b1;
      if (rxv[k] && rxr[k]) begin
        chk("lb_order", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("lb_data", rxd[k], e);
          chk("lb_flags", {rxpe[k], rxfe[k]}, 0);
        end
        got++;
      end
      if (i < n && txr[k] && (!rnd || $urandom_range(0, 3) != 0)) begin
        txd[k] = vals[i];
        txv[k] = 1'b1;
        q.push_back(vals[i]);
        i++;
      end else txv[k] = 1'b0;
    end
    @(negedge clk);
    txv[k] = 1'b0;
    rxr[k] = 1'b0;
    ena[k] = 1'b1;
    chk("lb_count", got, n);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    logic [7:0] t;
    tbl[0] = '{8'hA5, 1, 0, 1'b1, 1'b0};
    tbl[1] = '{8'hA5, 0, 0, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 0, 1, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1, 0, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 0, 0, 1'b0, 1'b0};
    tbl[5] = '{8'h81, 1, 1, 1'b1, 1'b1};
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ena[k] = 1'b1; txv[k] = 1'b0; txd[k] = '0; drv[k] = 1'b1;
      loop[k] = 1'b1; rxr[k] = 1'b0; ec[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_tx_signal", txs[0], 1);
    chk("rst_tx_ready", txr[0], 1);
    chk("rst_tx_busy", txb[0], 0);
    chk("rst_rx_valid", rxv[0], 0);
    chk("rst_rx_data", rxd[0], 0);
    chk("rst_rx_perr", rxpe[0], 0);
    chk("rst_rx_ferr", rxfe[0], 0);
    chk("rst_overrun", rxo[0], 0);
    chk("rst_tx_count", txc[0], 0);
    chk("rst_rx_count", rxc[0], 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    txd[0] = 8'h00;
    txv[0] = 1'b1;
    @(negedge clk);
    txv[0] = 1'b0;
    n = 1;
    while (txs[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("start_latency_ok", n <= 4, 1);
    chk("busy_in_frame", txb[0], 1);
    n = 0;
    while (!txs[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("zero_low_run", n, 144);
    wait_rx(0, 100);
    chk("zero_data", rxd[0], 8'h00);
    chk("zero_flags", {rxpe[0], rxfe[0]}, 0);
    pop(0);
    repeat (20) @(negedge clk);
    chk("idle_busy", txb[0], 0);
    chk("idle_rx_valid", rxv[0], 0);
    ena[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      txd[0] = 8'(i * 7 + 3);
      txv[0] = 1'b1;
    end
    @(negedge clk);
    chk("burst_full_ready", txr[0], 0);
    chk("burst_full_count", txc[0], 16);
    txd[0] = 8'hEE;
    @(negedge clk);
    txv[0] = 1'b0;
    chk("burst_refused", txc[0], 16);
    chk("frozen_busy", txb[0], 1);
    ena[0] = 1'b1;
    n = 0;
    while (rxc[0] != 16 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("burst_rx_count", rxc[0], 16);
    chk("burst_no_overrun", rxo[0], 0);
    @(negedge clk) begin txd[0] = 8'h99; txv[0] = 1'b1; end
    @(negedge clk) txv[0] = 1'b0;
    n = 0;
    while (!rxo[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("overrun_set", rxo[0], 1);
    chk("overrun_count", rxc[0], 16);
    for (int i = 0; i < 16; i++) begin
      chk("burst_order", rxd[0], 8'(i * 7 + 3));
      pop(0);
    end
    chk("burst_drained", rxv[0], 0);
    chk("overrun_sticky", rxo[0], 1);
    @(negedge clk) ec[0] = 1'b1;
    @(negedge clk) ec[0] = 1'b0;
    chk("overrun_cleared", rxo[0], 0);
    loop[0] = 1'b0;
    repeat (20) @(negedge clk);
    drive_frame(0, 8'h3C, 0, 1);
    wait_rx(0, 100);
    chk("ferr_data", rxd[0], 8'h3C);
    chk("ferr_flag", rxfe[0], 1);
    chk("ferr_perr", rxpe[0], 0);
    pop(0);
    repeat (20) @(negedge clk);
    drive_frame(0, 8'h5A, 0, 0);
    wait_rx(0, 100);
    chk("good_data", rxd[0], 8'h5A);
    chk("good_ferr", rxfe[0], 0);
    pop(0);
    repeat (20) @(negedge clk);
    drv[0] = 1'b0;
    repeat (3) @(negedge clk);
    drv[0] = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_rx_valid", rxv[0], 0);
    chk("glitch_rx_count", rxc[0], 0);
    drive_frame(0, 8'h81, 0, 0);
    wait_rx(0, 100);
    chk("post_glitch_data", rxd[0], 8'h81);
    pop(0);
    loop[1] = 1'b0;
    for (int v = 0; v < 6; v++) begin
      repeat (20) @(negedge clk);
      drive_frame(1, tbl[v].d, tbl[v].badp, tbl[v].stoplow);
      wait_rx(1, 100);
      chk("tbl_data", rxd[1], tbl[v].d);
      chk("tbl_perr", rxpe[1], tbl[v].pe);
      chk("tbl_ferr", rxfe[1], tbl[v].fe);
      pop(1);
    end
    loop[1] = 1'b1;
    for (int i = 0; i < 24; i++) vals[i] = 8'($urandom);
    repeat (20) @(negedge clk);
    stream(1, 24, 1);
    loop[0] = 1'b1;
    repeat (20) @(negedge clk);
    @(negedge clk) begin txd[0] = 8'hA7; txv[0] = 1'b1; end
    @(negedge clk) txd[0] = 8'h5E;
    @(negedge clk) txv[0] = 1'b0;
    n = 0;
    while (txs[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (88) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx_signal", txs[0], 1);
    chk("midrst_tx_count", txc[0], 0);
    chk("midrst_rx_count", rxc[0], 0);
    chk("midrst_busy", txb[0], 0);
    reset = 1'b0;
    @(negedge clk);
    vals[0] = 8'hC3;
    stream(0, 1, 0);
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      n = $urandom_range(0, i);
      t = vals[i];
      vals[i] = vals[n];
      vals[n] = t;
    end
    stream(0, 256, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_fifo_link.md
# uart_fifo_link

Buffered, parametrised UART transceiver that supersedes the single-word `uart` block. It adds TX/RX FIFOs, configurable parity and stop bits, 16x-oversampled receive with false-start rejection, and per-word error reporting. It sits between the board serial pins and the on-chip valid/ready byte streams of the link.

## Interface
- DATA_WIDTH, 8: payload bits per frame (5..9)
- BAUD_RATE, 115_200: line rate, bits/s
- CLK_FREQ, 50_000_000: clk frequency, Hz
- OVERSAMPLE, 16: baud ticks per bit (even, ≥4)
- FIFO_DEPTH, 16: entries per FIFO (power of 2, ≥2)
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ena  in  1  0 freezes baud tick and both serial FSMs; FIFO handshakes stay live
- tx_data  in  DATA_WIDTH  word to send
- tx_valid  in  1  push request
- tx_ready  out  1  TX FIFO not full
- tx_signal  out  1  serial out, idle high
- tx_busy  out  1  TX FSM not IDLE or TX FIFO non-empty
- rx_signal  in  1  serial in, asynchronous
- rx_data  out  DATA_WIDTH  head of RX FIFO (first-word fall-through)
- rx_parity_err  out  1  head word failed parity (0 when PARITY=0)
- rx_frame_err  out  1  head word had a low stop bit
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  pop request
- rx_overrun  out  1  sticky: word dropped on full RX FIFO
- err_clear  in  1  clears rx_overrun
- tx_count, rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancies

## Operation
- Baud tick: divider DIV = max(1, round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE))); one-cycle tick when counter hits DIV-1, then wraps to 0; counter holds while ena=0.
- Frame: start(0), DATA_WIDTH bits LSB first, optional parity, STOP_BITS×1; each bit lasts OVERSAMPLE ticks. Odd parity: XOR(data)^parity=1; even: =0.
- TX FSM IDLE→START→DATA→PARITY (skipped if PARITY=0)→STOP→IDLE. IDLE pops TX FIFO when non-empty; back-to-back frames with no idle gap when FIFO stays non-empty.
- RX: 2-flop synchroniser (reset value 1). FSM IDLE→START on falling edge; at OVERSAMPLE/2 ticks re-samples: high → IDLE (false start, no write). Data, parity, stop sampled at bit centre. Only the first stop bit is checked.
- At first-stop-bit centre, {data, parity_err, frame_err} written to RX FIFO; if full, word discarded and rx_overrun set. FSM returns to IDLE immediately (resync on next falling edge).
- Push accepted when tx_valid&tx_ready; pop when rx_valid&rx_ready. Ready/valid derive from registered counts only; a push on a full FIFO is refused even with a same-cycle pop.
- err_clear and a new overrun in the same cycle: overrun wins (stays 1).
- ena=0 mid-frame: tx_signal holds current bit; resumes on ena=1 without corruption.
- reset mid-frame: FSMs to IDLE, FIFOs emptied, tx_signal=1 next edge; partial frame lost.

## Timing
- Reset values: tx_signal=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0, counts=0.
- Push to start bit: start bit on tx_signal ≤ 2 cycles + one tick after push into an idle TX path.
- Frame length = OVERSAMPLE·(1+DATA_WIDTH+(PARITY≠0)+STOP_BITS) ticks.
- rx_valid rises the cycle after the RX FIFO write; rx_data/err flags stable while rx_valid=1 and no pop.
- Loopback (tx_signal→rx_signal) word latency ≈ (frame length − (STOP_BITS−0.5)·OVERSAMPLE) ticks + 4 cycles.

## Test plan
- Loopback, CLK_FREQ=1_600_000, BAUD_RATE=100_000 (DIV=1, 16 cycles/bit), 8N1: all 256 values -> each received equal, no error flags.
- Burst 16 pushes while rx_ready=0 -> tx_ready low after 16th; all 16 received in order; 17th received frame sets rx_overrun, err_clear clears it.
- PARITY=2, rx_signal driven with 0xA5 and wrong parity -> rx_data=0xA5, rx_parity_err=1; correct parity -> 0.
- Stop bit forced low on 0x3C -> rx_frame_err=1 with rx_data=0x3C.
- 3-cycle low glitch on idle rx_signal -> no write, rx_valid stays 0.
- reset asserted mid-frame (after bit 3) -> next cycle tx_signal=1, counts=0; next push transmits cleanly.
